// File: rtl/rename_pkg.sv
// Shared types and sizing for the rename stage and its free list.
// Optional flush recovery is enabled with the RENAME_FLUSH_EN macro.
package rename_pkg;
  localparam int NUM_ARCH = 32;
  localparam int NUM_TAGS = 64;
  localparam int FL_DEPTH = NUM_TAGS - NUM_ARCH;
  localparam int AREG_W   = $clog2(NUM_ARCH);
  localparam int TAG_W    = $clog2(NUM_TAGS);
  localparam int PTR_W    = $clog2(FL_DEPTH);
  localparam int CNT_W    = $clog2(FL_DEPTH + 1);

  typedef logic [AREG_W-1:0] areg_t;
  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [PTR_W-1:0]  fl_ptr_t;
  typedef logic [CNT_W-1:0]  fl_cnt_t;

  typedef struct packed {
    logic       valid;
    areg_t      arch_rd;
    tag_t       tag_rd;
    tag_t [1:0] tag_rs;
  } rename_out_t;

  // Circular pointer advance; wraps at FL_DEPTH even if it is not a power of two.
  function automatic fl_ptr_t fl_ptr_inc(input fl_ptr_t p);
    return (p == fl_ptr_t'(FL_DEPTH - 1)) ? '0 : p + fl_ptr_t'(1);
  endfunction
endpackage

// File: rtl/rename_free_list.sv
// Circular FIFO of free physical tags. Alloc pops at head, free pushes at tail.
// With RENAME_FLUSH_EN a commit_head pointer tracks retired allocations so a
// rewind returns every in-flight tag to the free pool in one cycle.
module rename_free_list
  import rename_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    alloc_en,
  output tag_t    alloc_tag,
  input  logic    free_en,
  input  tag_t    free_tag,
`ifdef RENAME_FLUSH_EN
  input  logic    rewind,
`endif
  output logic    empty,
  output fl_cnt_t count
);
  tag_t    fl [FL_DEPTH];
  fl_ptr_t head, tail;
  fl_cnt_t cnt;

  assign alloc_tag = fl[head];
  assign empty     = (cnt == '0);
  assign count     = cnt;

  // Tag storage: preload the non-architectural tags, then accept returned tags at tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++) fl[i] <= tag_t'(NUM_ARCH + i);
    end else if (free_en) begin
      fl[tail] <= free_tag;
    end
  end

`ifdef RENAME_FLUSH_EN
  fl_ptr_t commit_head;

  // commit_head moves once per real retire: slots between it and head are in flight.
  always_ff @(posedge clk) begin
    if (rst)          commit_head <= '0;
    else if (free_en) commit_head <= fl_ptr_inc(commit_head);
  end
`endif

  // Head/tail/count bookkeeping; a simultaneous alloc and free leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= fl_cnt_t'(FL_DEPTH);
    end else begin
      if (free_en) tail <= fl_ptr_inc(tail);
`ifdef RENAME_FLUSH_EN
      if (rewind) begin
        head <= free_en ? fl_ptr_inc(commit_head) : commit_head;
        cnt  <= fl_cnt_t'(FL_DEPTH);
      end else
`endif
      begin
        if (alloc_en) head <= fl_ptr_inc(head);
        if (alloc_en && !free_en)      cnt <= cnt - fl_cnt_t'(1);
        else if (!alloc_en && free_en) cnt <= cnt + fl_cnt_t'(1);
      end
    end
  end

  // More frees than allocations, or popping an empty list, means the ROB handshake broke.
  assert property (@(posedge clk) disable iff (rst)
    !(free_en && !alloc_en && cnt == fl_cnt_t'(FL_DEPTH)));
  assert property (@(posedge clk) disable iff (rst) !(alloc_en && cnt == '0));
endmodule

// File: rtl/rename_unit.sv
// Register-rename stage feeding the ROB: speculative RAT lookup, rd tag
// allocation, retirement RAT upkeep and superseded-tag recycling.
// RENAME_FLUSH_EN adds single-cycle flush recovery (RAT <= RRAT, free list rewind).
module rename_unit
  import rename_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       stall_in,
  input  logic       in_valid,
  input  areg_t [1:0] arch_rs,
  input  areg_t      arch_rd,
  input  logic       rd_we,
  input  logic       retire_valid,
  input  areg_t      retire_reg,
  input  tag_t       retire_tag,
  input  logic       flush,
  output logic       out_valid,
  output areg_t      out_arch_rd,
  output tag_t       out_tag_rd,
  output tag_t [1:0] out_tag_rs,
  output logic       rename_stall
);
  tag_t        rat  [NUM_ARCH];
  tag_t        rrat [NUM_ARCH];
  rename_out_t out_q, out_d;
  logic        need_tag, accept, alloc_en, do_retire, fl_empty, flushing;
  tag_t        alloc_tag;
  fl_cnt_t     unused_fl_count;

`ifdef RENAME_FLUSH_EN
  assign flushing = flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flushing     = 1'b0;
`endif

  // x0 is never renamed, and retiring x0 carries no tag to recycle.
  assign need_tag     = rd_we && (arch_rd != '0);
  assign do_retire    = retire_valid && (retire_reg != '0);
  assign accept       = in_valid && !stall_in && !flushing && !(need_tag && fl_empty);
  assign alloc_en     = accept && need_tag;
  assign rename_stall = in_valid && !accept;

  rename_free_list u_fl (
    .clk       (clk),
    .rst       (rst),
    .alloc_en  (alloc_en),
    .alloc_tag (alloc_tag),
    .free_en   (do_retire),
    .free_tag  (rrat[retire_reg]),
`ifdef RENAME_FLUSH_EN
    .rewind    (flush),
`endif
    .empty     (fl_empty),
    .count     (unused_fl_count)
  );

  // Sources read the RAT as it stood before this instruction's own rd write.
  always_comb begin
    out_d         = '0;
    out_d.valid   = accept;
    out_d.arch_rd = need_tag ? arch_rd : '0;
    out_d.tag_rd  = need_tag ? alloc_tag : '0;
    for (int i = 0; i < 2; i++)
      out_d.tag_rs[i] = (arch_rs[i] == '0) ? '0 : rat[arch_rs[i]];
  end

  // Speculative RAT: identity at reset, updated by each allocation.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH; i++) rat[i] <= tag_t'(i);
`ifdef RENAME_FLUSH_EN
    end else if (flush) begin
      // Restore committed state, folding in a retire landing in the same cycle.
      for (int i = 0; i < NUM_ARCH; i++)
        rat[i] <= (do_retire && retire_reg == areg_t'(i)) ? retire_tag : rrat[i];
`endif
    end else if (alloc_en) begin
      rat[arch_rd] <= alloc_tag;
    end
  end

  // Retirement RAT: the displaced mapping goes back to the free list via free_tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH; i++) rrat[i] <= tag_t'(i);
    end else if (do_retire) begin
      rrat[retire_reg] <= retire_tag;
    end
  end

  // Output register: held under stall_in, otherwise loads this cycle's result.
  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
`ifdef RENAME_FLUSH_EN
    else if (flush) out_q.valid <= 1'b0;
`endif
    else if (!stall_in) out_q <= out_d;
  end

  assign out_valid   = out_q.valid;
  assign out_arch_rd = out_q.arch_rd;
  assign out_tag_rd  = out_q.tag_rd;
  assign out_tag_rs  = out_q.tag_rs;
endmodule

// File: tb/tb_rename_unit.sv
// Scoreboard bench for rename_unit: a queue/array reference model predicts each
// accepted rename; a negedge monitor pops and compares when the DUT hands off.
module tb_rename_unit;
  import rename_pkg::*;

  logic       clk = 1'b0;
  logic       rst, stall_in, in_valid, rd_we, retire_valid, flush;
  areg_t [1:0] arch_rs;
  areg_t      arch_rd, retire_reg;
  tag_t       retire_tag;
  logic       out_valid, rename_stall;
  areg_t      out_arch_rd;
  tag_t       out_tag_rd;
  tag_t [1:0] out_tag_rs;

  rename_unit dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .in_valid(in_valid),
    .arch_rs(arch_rs), .arch_rd(arch_rd), .rd_we(rd_we),
    .retire_valid(retire_valid), .retire_reg(retire_reg), .retire_tag(retire_tag),
    .flush(flush), .out_valid(out_valid), .out_arch_rd(out_arch_rd),
    .out_tag_rd(out_tag_rd), .out_tag_rs(out_tag_rs), .rename_stall(rename_stall)
  );

  always #5 clk = ~clk;

  typedef struct { int ard; int trd; int trs0; int trs1; } exp_t;
  typedef struct { int r; int t; } pair_t;

  exp_t  sb[$];
  pair_t infl[$];     // renamed-with-rd instructions, oldest first (the ROB)
  int    rat[32];
  int    rrat[32];
  int    freeq[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  exp_t  me;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin rat[i] = i; rrat[i] = i; end
    freeq.delete();
    for (int i = 32; i < 64; i++) freeq.push_back(i);
    infl.delete();
    sb.delete();
  endtask

  // One cycle: drive, check rename_stall, advance model, wait past the edge.
  // rmode: 0 no retire, 1 retire oldest in-flight, 2 junk retire of x0.
  task automatic step(input bit iv, input int rs0, input int rs1, input int rd,
                      input bit we, input bit sin, input int rmode, input bit fl_in);
    pair_t rp;
    exp_t  e;
    bit    need, acc, fl;
    int    rr, rt;
    rr = 0; rt = 0; fl = fl_in;
`ifndef RENAME_FLUSH_EN
    fl = 1'b0;
`endif
    if (rmode == 1 && infl.size() > 0) begin
      rp = infl.pop_front(); rr = rp.r; rt = rp.t;
    end else if (rmode == 2) begin
      rt = $urandom_range(63);
    end
    in_valid = iv; arch_rs[0] = areg_t'(rs0); arch_rs[1] = areg_t'(rs1);
    arch_rd = areg_t'(rd); rd_we = we; stall_in = sin; flush = fl;
    retire_valid = (rmode == 2) || (rr != 0);
    retire_reg = areg_t'(rr); retire_tag = tag_t'(rt);
    #1;
    need = we && (rd != 0);
    acc  = iv && !sin && !fl && !(need && freeq.size() == 0);
    chk("rename_stall", int'(rename_stall), int'(iv && !acc));
    if (acc) begin
      e.trs0 = (rs0 == 0) ? 0 : rat[rs0];
      e.trs1 = (rs1 == 0) ? 0 : rat[rs1];
      if (need) begin
        e.trd = freeq.pop_front(); e.ard = rd; rat[rd] = e.trd;
        infl.push_back('{rd, e.trd});
      end else begin
        e.trd = 0; e.ard = 0;
      end
      sb.push_back(e);
    end
    if (rr != 0) begin freeq.push_back(rrat[rr]); rrat[rr] = rt; end
    if (fl) begin
      rat = rrat;
      for (int i = infl.size() - 1; i >= 0; i--) freeq.push_front(infl[i].t);
      infl.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("sb_drained", sb.size(), 0);
  endtask

  // Reset with garbage on every other input; state must come back regardless.
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b1; stall_in = 1'(($urandom_range(1)));
    rd_we = 1'b1; arch_rd = areg_t'($urandom_range(31));
    arch_rs[0] = areg_t'($urandom_range(31)); arch_rs[1] = areg_t'($urandom_range(31));
    retire_valid = 1'b1; retire_reg = areg_t'($urandom_range(1, 31));
    retire_tag = tag_t'($urandom_range(63)); flush = 1'b0;
    @(posedge clk); #1;
    model_reset();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_arch_rd", int'(out_arch_rd), 0);
    chk("rst_out_tag_rd", int'(out_tag_rd), 0);
    chk("rst_out_tag_rs0", int'(out_tag_rs[0]), 0);
    chk("rst_out_tag_rs1", int'(out_tag_rs[1]), 0);
    stall_in = 1'b0; retire_valid = 1'b0; arch_rd = 5'd7;
    #1 chk("rst_rename_stall", int'(rename_stall), 0);
    in_valid = 1'b0; rst = 1'b0;
  endtask

  // Monitor: a result is handed off at an edge where out_valid & ~stall_in.
  always @(negedge clk) begin
    if (!rst && out_valid && !stall_in) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_out: got tag_rd %0d expected no output", out_tag_rd);
      end else begin
        me = sb.pop_front();
        chk("out_arch_rd", int'(out_arch_rd), me.ard);
        chk("out_tag_rd", int'(out_tag_rd), me.trd);
        chk("out_tag_rs0", int'(out_tag_rs[0]), me.trs0);
        chk("out_tag_rs1", int'(out_tag_rs[1]), me.trs1);
      end
    end
  end

  initial begin
    int  rmode, rp;
    bit  sin, fl;
    rst = 1'b1; stall_in = 0; in_valid = 0; rd_we = 0; retire_valid = 0; flush = 0;
    arch_rs = '0; arch_rd = '0; retire_reg = '0; retire_tag = '0;
    do_reset();

    // Basic rename and back-to-back dependency.
    step(1, 1, 2, 5, 1, 0, 0, 0);
    chk("t1_tag_rd", int'(out_tag_rd), 32);
    chk("t1_tag_rs0", int'(out_tag_rs[0]), 1);
    chk("t1_tag_rs1", int'(out_tag_rs[1]), 2);
    step(1, 5, 0, 5, 1, 0, 0, 0);
    chk("t1b_tag_rd", int'(out_tag_rd), 33);
    chk("t1b_tag_rs0", int'(out_tag_rs[0]), 32);
    drain();

    // Mid-operation reset, then rs==rd and rd=x0.
    do_reset();
    step(1, 3, 0, 3, 1, 0, 0, 0);
    chk("t2_rs0_old", int'(out_tag_rs[0]), 3);
    chk("t2_tag_rd", int'(out_tag_rd), 32);
    step(1, 3, 4, 0, 1, 0, 0, 0);
    chk("t2_x0_tag_rd", int'(out_tag_rd), 0);
    chk("t2_x0_rs0", int'(out_tag_rs[0]), 32);
    step(1, 0, 0, 9, 1, 0, 0, 0);
    chk("t2_next_tag", int'(out_tag_rd), 33);
    drain();

    // Exhaust the free list, stall, retire x5 to recover tag 5.
    do_reset();
    step(1, 0, 0, 5, 1, 0, 0, 0);
    for (int i = 0; i < 31; i++)
      step(1, $urandom_range(31), $urandom_range(31), $urandom_range(1, 31), 1, 0, 0, 0);
    step(1, 1, 2, 6, 1, 0, 0, 0);
    chk("t3_no_out", int'(out_valid), 0);
    step(1, 1, 2, 6, 1, 0, 1, 0);
    step(1, 1, 2, 6, 1, 0, 0, 0);
    chk("t3_tag5", int'(out_tag_rd), 5);

    // count=1 with alloc+retire every cycle: pointers wrap, count must hold.
    step(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 40; i++)
      step(1, $urandom_range(31), $urandom_range(31), $urandom_range(1, 31), 1, 0, 1, 0);
    step(1, 2, 3, 4, 1, 0, 0, 0);
    step(1, 2, 3, 4, 1, 0, 0, 0);

    // Downstream stall holds the output register for three cycles.
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 7, 8, 9, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 9, 1, 10, 1, 1, 0, 0);
      chk("t4_held_valid", int'(out_valid), 1);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    drain();

`ifdef RENAME_FLUSH_EN
    do_reset();
    step(1, 0, 0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 2, 1, 0, 0, 0);
    step(1, 0, 0, 3, 1, 0, 0, 0);
    step(1, 0, 0, 4, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 2, 5, 1, 0, 0, 1);
    chk("t6_flush_valid", int'(out_valid), 0);
    step(1, 2, 1, 6, 1, 0, 0, 0);
    chk("t6_tag_rd", int'(out_tag_rd), 33);
    chk("t6_rs0_rrat", int'(out_tag_rs[0]), 2);
    chk("t6_rs1_rrat", int'(out_tag_rs[1]), 32);
    drain();
`endif

    // Randomized traffic: low retire rate first (fills up), then higher.
    for (int c = 0; c < 1500; c++) begin
      sin = ($urandom_range(99) < 15);
      fl = 1'b0;
      rp = (c < 500) ? 15 : 55;
      rmode = 0;
      if (infl.size() > 0 && $urandom_range(99) < rp) rmode = 1;
      else if ($urandom_range(99) < 4) rmode = 2;
`ifdef RENAME_FLUSH_EN
      if (!sin && $urandom_range(99) < 2) fl = 1'b1;
`endif
      step($urandom_range(99) < 80, $urandom_range(31), $urandom_range(31),
           $urandom_range(31), $urandom_range(99) < 85, sin, rmode, fl);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
